deco_pipe: RTL

- Registered, parametrised instruction-decode stage between fetch and register-read.
- Accepts raw instructions over a valid/ready handshake and decodes them into class, register fields, address and immediate.
- Decoded records sit in a 2-entry buffer so fetch is never blocked combinationally by downstream stalls.
- Adds what the combinational decoder lacks: an illegal-opcode flag, pipeline flush, and saturating per-class instruction counters.

---
 rtl/deco_pkg.sv | 49 ++++
 rtl/deco_core.sv | 67 ++++++
 rtl/deco_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/deco_pkg.sv
// Shared types and constants for the decode stage.
// Records use fixed maximum field widths; the stage trims them to its parameters.
package deco_pkg;

  localparam logic [1:0] TYPE_RR  = 2'b00;
  localparam logic [1:0] TYPE_MEM = 2'b01;
  localparam logic [1:0] TYPE_BR  = 2'b10;
  localparam logic [1:0] TYPE_IMM = 2'b11;

  localparam logic [2:0] K_RR_A  = 3'b010;
  localparam logic [2:0] K_RR_B  = 3'b100;
  localparam logic [2:0] K_MEM_A = 3'b001;
  localparam logic [2:0] K_MEM_B = 3'b011;
  localparam logic [2:0] K_BR_A  = 3'b101;
  localparam logic [2:0] K_BR_B  = 3'b110;
  localparam logic [2:0] K_IMM_A = 3'b000;
  localparam logic [2:0] K_IMM_B = 3'b111;

  localparam int REC_OPW  = 8;
  localparam int REC_REGW = 8;
  localparam int REC_DW   = 32;

  localparam int NCNT    = 5;
  localparam int CNT_ILL = 4;

  typedef struct packed {
    logic [1:0]          itype;
    logic [REC_OPW-1:0]  opcode;
    logic [REC_REGW-1:0] src1;
    logic [REC_REGW-1:0] src2;
    logic [REC_REGW-1:0] dest;
    logic [REC_DW-1:0]   addr;
    logic [REC_DW-1:0]   imm;
    logic                illegal;
  } rec_t;

  function automatic logic [1:0] class_of(input logic [2:0] k);
    logic [1:0] c;
    c = TYPE_IMM;
    unique case (1'b1)
      (k == K_RR_A)  || (k == K_RR_B):  c = TYPE_RR;
      (k == K_MEM_A) || (k == K_MEM_B): c = TYPE_MEM;
      (k == K_BR_A)  || (k == K_BR_B):  c = TYPE_BR;
      (k == K_IMM_A) || (k == K_IMM_B): c = TYPE_IMM;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/deco_core.sv
// Combinational instruction decoder: raw instruction to decoded record.
// Opcode bits below the top three must be zero, otherwise the record is illegal.
module deco_core
  import deco_pkg::*;
#(
  parameter int W = 16,
  parameter int O = 3,
  parameter int R = 3
) (
  input  logic [W-1:0] instruction,
  output rec_t         rec
);

  logic [2:0]   k;
  logic [O-1:0] op;
  logic [R-1:0] f1;
  logic [R-1:0] f2;
  logic [R-1:0] f3;
  logic [1:0]   cls;
  logic         ill;

  assign k   = instruction[W-1 -: 3];
  assign op  = instruction[W-1 -: O];
  assign f1  = instruction[W-O-1 -: R];
  assign f2  = instruction[W-O-R-1 -: R];
  assign f3  = instruction[W-O-2*R-1 -: R];
  assign cls = class_of(k);

  always_comb begin
    ill = 1'b0;
    for (int i = W - O; i < W - 3; i++) begin
      ill = ill | instruction[i];
    end
  end

  always_comb begin
    rec        = '0;
    rec.opcode = REC_OPW'(op);
    unique case (1'b1)
      ill: begin
        rec.itype   = TYPE_IMM;
        rec.illegal = 1'b1;
      end
      !ill && (cls == TYPE_RR): begin
        rec.itype = TYPE_RR;
        rec.dest  = REC_REGW'(f1);
        rec.src1  = REC_REGW'(f2);
        rec.src2  = REC_REGW'(f3);
      end
      !ill && (cls == TYPE_MEM): begin
        rec.itype = TYPE_MEM;
        rec.src1  = REC_REGW'(f1);
        rec.src2  = REC_REGW'(f2);
      end
      !ill && (cls == TYPE_BR): begin
        rec.itype = TYPE_BR;
        rec.addr  = REC_DW'(instruction[W-O-1:0]);
      end
      !ill && (cls == TYPE_IMM): begin
        rec.itype = TYPE_IMM;
        rec.src1  = REC_REGW'(f1);
        rec.imm   = REC_DW'(instruction[W-O-R-1:0]);
      end
    endcase
  end

endmodule

// File: rtl/deco_pipe.sv
// Registered decode stage: decoder, 2-entry record buffer, flush and
// saturating per-class counters of accepted instructions.
module deco_pipe
  import deco_pkg::*;
#(
  parameter int INSTRUCTION_SIZE = 16,
  parameter int OPCODE_SIZE      = 3,
  parameter int REG_ADDR         = 3,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           flush,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [INSTRUCTION_SIZE-1:0]                    instruction,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [1:0]                                     itype,
  output logic [OPCODE_SIZE-1:0]                         opcode,
  output logic [REG_ADDR-1:0]                            src1,
  output logic [REG_ADDR-1:0]                            src2,
  output logic [REG_ADDR-1:0]                            dest,
  output logic [INSTRUCTION_SIZE-OPCODE_SIZE-1:0]        addr,
  output logic [INSTRUCTION_SIZE-OPCODE_SIZE-REG_ADDR-1:0] imm,
  output logic                                           illegal,
  output logic [CNT_WIDTH-1:0]                           cnt_rr,
  output logic [CNT_WIDTH-1:0]                           cnt_mem,
  output logic [CNT_WIDTH-1:0]                           cnt_br,
  output logic [CNT_WIDTH-1:0]                           cnt_imm,
  output logic [CNT_WIDTH-1:0]                           cnt_ill
);

  localparam int W = INSTRUCTION_SIZE;
  localparam int O = OPCODE_SIZE;
  localparam int R = REG_ADDR;

  rec_t        dec;
  rec_t        slot0;
  rec_t        slot1;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  logic [NCNT-1:0] hit;
  logic [CNT_WIDTH-1:0] cnt [NCNT];

  deco_core #(.W(W), .O(O), .R(R)) u_core (
    .instruction (instruction),
    .rec         (dec)
  );

  assign in_ready  = (count != 2'd2) & ~flush;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // slot0 is the head and is only rewritten when a new record takes its place
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            slot0 <= dec;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0 <= dec;
          end else if (push) begin
            slot1 <= dec;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            slot0 <= slot1;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  always_comb begin
    hit = '0;
    if (push) begin
      if (dec.illegal) hit[CNT_ILL] = 1'b1;
      else hit[dec.itype] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCNT; i++) begin
      if (rst) cnt[i] <= '0;
      else if (hit[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_WIDTH'(1);
    end
  end

  assign cnt_rr  = cnt[0];
  assign cnt_mem = cnt[1];
  assign cnt_br  = cnt[2];
  assign cnt_imm = cnt[3];
  assign cnt_ill = cnt[CNT_ILL];

  assign itype   = slot0.itype;
  assign opcode  = slot0.opcode[O-1:0];
  assign src1    = slot0.src1[R-1:0];
  assign src2    = slot0.src2[R-1:0];
  assign dest    = slot0.dest[R-1:0];
  assign addr    = slot0.addr[W-O-1:0];
  assign imm     = slot0.imm[W-O-R-1:0];
  assign illegal = slot0.illegal;

  logic unused_hi;
  assign unused_hi = ^{slot0.opcode[REC_OPW-1:O],
                       slot0.src1[REC_REGW-1:R],
                       slot0.src2[REC_REGW-1:R],
                       slot0.dest[REC_REGW-1:R],
                       slot0.addr[REC_DW-1:W-O],
                       slot0.imm[REC_DW-1:W-O-R]};

endmodule
